// File: rtl/axis_join_arbiter_rr.sv
// Packet-granular S_COUNT:1 AXI4-Stream arbiter mux with registered, source-tagged output.
// state | meaning:  IDLE | no grant, arbitrating   BUSY | grant held until tlast accepted
module axis_join_arbiter_rr #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ARB_MODE   = 0,
    parameter int ID_WIDTH   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT-1:0]            ien,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    output logic [S_COUNT-1:0]            s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [ID_WIDTH-1:0]   upper_idx;
    logic [ID_WIDTH-1:0]   lower_idx;
    logic                  upper_found;
    logic [S_COUNT-1:0]    req;
    logic                  out_free;
    logic                  beat;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  sel_valid;

    assign req      = ien & s_axis_tvalid;
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign busy     = (state == BUSY);
    assign beat     = busy && sel_valid && out_free;

    // Round-robin takes the lowest requester above last_grant, wrapping to the lowest overall.
    always_comb begin
        upper_idx   = '0;
        lower_idx   = '0;
        upper_found = 1'b0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (req[i]) begin
                lower_idx = ID_WIDTH'(i);
                if (ID_WIDTH'(i) > last_grant) begin
                    upper_idx   = ID_WIDTH'(i);
                    upper_found = 1'b1;
                end
            end
        end
        if (ARB_MODE == 1 || !upper_found) pick_idx = lower_idx;
        else                               pick_idx = upper_idx;
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = s_axis_tlast[i];
                sel_valid = s_axis_tvalid[i];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (busy && grant_idx == ID_WIDTH'(i)) s_axis_tready[i] = out_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant_idx     <= '0;
            last_grant    <= ID_WIDTH'(S_COUNT - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant_idx <= pick_idx;
                        if (ARB_MODE == 0) last_grant <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat && sel_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (beat) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= sel_last;
                m_axis_tid    <= grant_idx;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_join_arbiter_rr.sv
// Scoreboard bench: round-robin instance checked against a packet-level reference model,
// plus a fixed-priority instance exercised with two competing inputs.
module tb_axis_join_arbiter_rr;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [2:0]    gap;
        logic          clr_ien;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } exp_t;

    typedef struct {
        int   cyc;
        int   id;
        logic last;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    ien, s_tvalid, s_tlast, s_tready;
    logic [N*DW-1:0] s_tdata;
    logic            m_tvalid, m_tlast, m_tready, busy;
    logic [DW-1:0]   m_tdata;
    logic [IW-1:0]   m_tid;

    logic [N-1:0]    f_ien = 4'hF;
    logic [N-1:0]    f_tvalid, f_tlast, f_tready;
    logic [N*DW-1:0] f_tdata;
    logic            f_mvalid, f_mlast, f_busy;
    logic [DW-1:0]   f_mdata;
    logic [IW-1:0]   f_mid;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    beat_t        src_q[N][$];
    exp_t         exp_q[$];
    obs_t         obs_q[$];
    int           f_obs[$];
    int           hold[N];
    int           acc_cnt[N];
    int           f_cnt[N];
    logic [N-1:0] acc_flag = '0;
    logic [N-1:0] f_acc = '0;
    logic [N-1:0] ien_base = 4'hF;
    logic [N-1:0] ien_clr = '0;
    int           restore_req = 0;
    int           restore_seen = 0;
    logic         gap_en = 1'b0;
    logic         rand_ien = 1'b0;
    int           rdy_mode = 0;
    int           rdy_ph = 0;

    // reference model state
    logic mb = 1'b0;
    logic mov = 1'b0;
    int   mg = 0;
    int   mlast = N - 1;

    axis_join_arbiter_rr #(.S_COUNT(N), .DATA_WIDTH(DW), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst), .ien(ien), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .m_axis_tvalid(m_tvalid),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tready(m_tready), .busy(busy));

    axis_join_arbiter_rr #(.S_COUNT(N), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .ien(f_ien), .s_axis_tvalid(f_tvalid), .s_axis_tdata(f_tdata),
        .s_axis_tlast(f_tlast), .s_axis_tready(f_tready), .m_axis_tvalid(f_mvalid),
        .m_axis_tdata(f_mdata), .m_axis_tlast(f_mlast), .m_axis_tid(f_mid),
        .m_axis_tready(1'b1), .busy(f_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int i, input int len, input logic [DW-1:0] base,
                           input int gap_beat, input int gap_len, input int clr_beat);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data    = base + DW'(b);
            x.last    = (b == len - 1);
            x.gap     = (b == gap_beat) ? 3'(gap_len) : 3'd0;
            x.clr_ien = (b == clr_beat);
            src_q[i].push_back(x);
        end
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int lim);
        int t = 0;
        while ((exp_q.size() != 0 || !src_empty() || mb || mov) && t < lim) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("drain_done", (t < lim), 1'b1);
    endtask

    // source drivers, output ready pattern and the fixed-priority instance's inputs
    initial begin : driver
        logic [N-1:0] r;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1; ien = 4'hF;
        f_tvalid = '0; f_tlast = '0; f_tdata = '0;
        forever begin
            @(posedge clk);
            #1;
            rdy_ph++;
            case (rdy_mode)
                1:       m_tready = 1'($urandom_range(1));
                2:       m_tready = (rdy_ph % 3 == 0);
                default: m_tready = 1'b1;
            endcase
            if (restore_seen != restore_req) begin
                ien_clr = '0;
                restore_seen = restore_req;
            end
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    src_q[i].delete();
                    hold[i] = 0;
                    f_cnt[i] = 0;
                end
                s_tvalid = '0;
                f_tvalid = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (acc_flag[i] && src_q[i].size() > 0) begin
                        if (src_q[i][0].clr_ien) ien_clr[i] = 1'b1;
                        hold[i] = int'(src_q[i][0].gap);
                        void'(src_q[i].pop_front());
                    end
                    if (s_tvalid[i] && !acc_flag[i]) begin
                    end else if (hold[i] > 0) begin
                        s_tvalid[i] = 1'b0;
                        hold[i]--;
                    end else begin
                        s_tvalid[i] = (src_q[i].size() > 0) && (!gap_en || $urandom_range(3) != 0);
                    end
                    if (src_q[i].size() > 0) begin
                        s_tdata[i*DW +: DW] = src_q[i][0].data;
                        s_tlast[i] = src_q[i][0].last;
                    end
                    if (f_acc[i]) f_cnt[i]++;
                end
                f_tvalid = 4'b1010;
            end
            for (int i = 0; i < N; i++) begin
                f_tlast[i] = f_cnt[i][0];
                f_tdata[i*DW +: DW] = {32'(i), 32'(f_cnt[i])};
                r[i] = ($urandom_range(3) != 0);
            end
            ien = rand_ien ? r : (ien_base & ~ien_clr);
        end
    end

    // reference model: checks the current cycle, then predicts the next edge
    always @(negedge clk) begin : model
        logic [N-1:0] er;
        logic [N-1:0] req;
        int w;
        if (rst) begin
            mb = 1'b0; mov = 1'b0; mlast = N - 1; acc_flag = '0;
            exp_q.delete();
        end else begin
            er = '0;
            if (mb) er[mg] = !mov || m_tready;
            check("s_tready", s_tready, er);
            check("busy", busy, mb);
            check("m_tvalid", m_tvalid, mov);
            acc_flag = er & s_tvalid;
            if (mb) begin
                if (acc_flag[mg]) begin
                    exp_q.push_back({s_tdata[mg*DW +: DW], s_tlast[mg], IW'(mg)});
                    acc_cnt[mg]++;
                    if (s_tlast[mg]) mb = 1'b0;
                end
            end else begin
                req = ien & s_tvalid;
                if (req != '0) begin
                    w = 0;
                    for (int k = 1; k <= N; k++) begin
                        w = (mlast + k) % N;
                        if (req[w]) break;
                    end
                    mb = 1'b1; mg = w; mlast = w;
                end
            end
            if (acc_flag != '0) mov = 1'b1;
            else if (m_tready) mov = 1'b0;
        end
    end

    // output monitor
    logic            pstall = 1'b0;
    logic [DW+IW:0]  pval = '0;
    logic            f_first = 1'b1;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            pstall = 1'b0;
            f_first = 1'b1;
            f_acc = '0;
        end else begin
            if (pstall) check("hold_stable", {m_tvalid, m_tdata, m_tlast, m_tid}, {1'b1, pval});
            pstall = m_tvalid && !m_tready;
            pval = {m_tdata, m_tlast, m_tid};
            if (m_tvalid && m_tready) begin
                obs_q.push_back('{cyc, int'(m_tid), m_tlast});
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_tdata, m_tlast, m_tid}, {e.data, e.last, e.id});
                end
            end
            f_acc = f_tvalid & f_tready;
            if (f_mvalid) begin
                if (f_first) f_obs.push_back(int'(f_mid));
                f_first = f_mlast;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, b0, k, ones;
        int st[$];
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tid", m_tid, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_s_tready", s_tready, 4'd0);
        rst = 1'b0;

        // round-robin fairness, 2-beat packets on all inputs
        @(posedge clk); #2;
        b0 = obs_q.size();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) add_pkt(i, 2, {32'(i), 32'(p << 8)}, -1, 0, -1);
        drain(400);
        for (int j = b0; j < obs_q.size(); j++) begin
            if (j == b0 || obs_q[j-1].last) begin
                st.push_back(obs_q[j].id);
                if (j > b0) check("pkt_gap", obs_q[j].cyc - obs_q[j-1].cyc, 2);
            end
        end
        check("rr_pkts", st.size(), 12);
        for (int j = 0; j < st.size(); j++) check("rr_order", st[j], j % 4);

        // single input latency
        @(posedge clk); #2;
        add_pkt(2, 4, 64'hA0, -1, 0, -1);
        @(posedge clk); #2;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!m_tvalid && n < 8);
        check("first_beat_latency", n, 2);
        check("first_beat_tid", m_tid, 2'd2);
        check("first_beat_data", m_tdata, 64'hA0);
        drain(100);

        // backpressure 1,0,0 on a 6-beat packet
        rdy_mode = 2;
        add_pkt(0, 6, 64'hB0, -1, 0, -1);
        drain(200);
        rdy_mode = 0;

        // ien drop after beat 2, tvalid gap after beat 3, competing inputs queued
        @(posedge clk); #2;
        b0 = obs_q.size();
        add_pkt(1, 5, 64'hC0, 2, 3, 1);
        n = 0;
        while (!(mb && mg == 1) && n < 20) begin @(posedge clk); #2; n++; end
        check("d_grant_wait", (n < 20), 1'b1);
        add_pkt(0, 2, 64'hE0, -1, 0, -1);
        add_pkt(2, 2, 64'hF0, -1, 0, -1);
        drain(200);
        check("d_count", (obs_q.size() >= b0 + 5), 1'b1);
        if (obs_q.size() >= b0 + 5)
            for (int j = 0; j < 5; j++) check("d_contig_id", obs_q[b0+j].id, 1);
        restore_req++;
        repeat (2) @(posedge clk);

        // randomized traffic
        gap_en = 1'b1; rdy_mode = 1; rand_ien = 1'b1;
        for (int p = 0; p < 40; p++) begin
            add_pkt($urandom_range(N - 1), $urandom_range(1, 6), {$urandom, $urandom}, -1, 0, -1);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #2;
        end
        drain(4000);
        gap_en = 1'b0; rdy_mode = 0; rand_ien = 1'b0;
        repeat (2) @(posedge clk);

        // fixed priority instance
        #2;
        ones = 0;
        foreach (f_obs[j]) if (f_obs[j] == 1) ones++;
        check("fp_pkts_seen", (f_obs.size() >= 3), 1'b1);
        check("fp_only_input1", ones, f_obs.size());
        k = f_obs.size();
        f_ien = 4'b1101;
        repeat (20) @(posedge clk);
        #2;
        ones = 0;
        for (int j = k; j < f_obs.size(); j++) if (f_obs[j] == 1) ones++;
        check("fp_switch_boundary", (ones <= 1), 1'b1);
        check("fp_switch_count", (f_obs.size() > k + 2), 1'b1);
        if (f_obs.size() > 0) check("fp_now_input3", f_obs[f_obs.size()-1], 3);

        // asynchronous reset during beat 3 of 5
        @(posedge clk); #2;
        k = acc_cnt[1];
        add_pkt(1, 5, 64'hD0, -1, 0, -1);
        n = 0;
        do begin
            @(posedge clk); #3;
            n++;
        end while (acc_cnt[1] < k + 3 && n < 30);
        check("g_beat3_wait", (n < 30), 1'b1);
        rst = 1'b1;
        #1;
        check("arst_m_tvalid", m_tvalid, 1'b0);
        check("arst_m_tdata", m_tdata, 64'd0);
        check("arst_m_tlast", m_tlast, 1'b0);
        check("arst_m_tid", m_tid, 2'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_s_tready", s_tready, 4'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #2;
        b0 = obs_q.size();
        add_pkt(2, 1, 64'h32, -1, 0, -1);
        add_pkt(1, 1, 64'h31, -1, 0, -1);
        add_pkt(0, 1, 64'h30, -1, 0, -1);
        drain(100);
        check("g_count", (obs_q.size() == b0 + 3), 1'b1);
        if (obs_q.size() > b0) check("g_first_winner", obs_q[b0].id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_join_arbiter_rr.md
# axis_join_arbiter_rr

Parametrised N-input AXI4-Stream packet arbiter mux that merges S_COUNT input streams into one output stream. Arbitration is packet-granular: a grant is held from the first beat until the tlast beat is accepted. The policy is round-robin or fixed-priority, gated per input by a runtime enable mask. The output is registered and tagged with the source index. It sits at the top of the datapath fan-in, replacing the fixed-width 3-port join wrappers with a single generic block.

## Interface
- S_COUNT, 4, number of input streams (2..16)
- DATA_WIDTH, 64, tdata width in bits
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- ID_WIDTH, $clog2(S_COUNT), width of m_axis_tid
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ien  in  S_COUNT  per-input arbitration enable; bit i=0 excludes input i from new grants
- s_axis_tvalid  in  S_COUNT  per-input valid
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tlast  in  S_COUNT  per-input end of packet
- s_axis_tready  out  S_COUNT  per-input ready; at most one bit high
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tlast  out  1  output last (registered)
- m_axis_tid  out  ID_WIDTH  index of the source input of the current beat
- m_axis_tready  in  1  output ready
- busy  out  1  high while a packet grant is held

## Operation
- States are IDLE and BUSY.
- **IDLE:**
  - The request vector is req = ien & s_axis_tvalid.
  - If req != 0, pick a winner, register grant_idx, and go to BUSY on the next edge.
  - s_axis_tready is all zero in IDLE.
- **Round-robin pick:** the first set bit of req scanning from (last_grant+1) mod S_COUNT upward with wrap. last_grant updates to the winner.
- **Fixed-priority pick:** the lowest set bit of req. last_grant is unused.
- **BUSY:**
  - s_axis_tready[grant_idx] = !m_axis_tvalid || m_axis_tready. All other bits are 0.
  - Each accepted beat loads tdata, tlast and grant_idx into the output register.
  - On an accepted beat with tlast=1, return to IDLE.
- **Output register:**
  - On an input beat, set m_axis_tvalid.
  - Clear m_axis_tvalid on output acceptance when no new beat is loaded the same cycle.
  - Output data is held stable while tvalid=1 and tready=0.
- **ien deasserted for the granted input mid-packet:** no effect; the packet completes. ien affects only new picks.
- **tvalid dropping mid-packet:** the grant is held and the block waits. Packets are never truncated or interleaved.
- **S_COUNT=1:** the block degenerates to a registered pass-through with the IDLE gap; m_axis_tid is 0.
- **Reset (asynchronous, any time including mid-packet):**
  - State goes to IDLE; busy=0, s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0.
  - last_grant=S_COUNT-1, so input 0 has top round-robin priority after reset.
  - Any partial packet is discarded.

## Timing
- **Arbitration latency:** a request visible in IDLE cycle N gives s_axis_tready high in cycle N+1 (if the output slot is free). The first beat appears on m_axis_* in cycle N+2.
- **Throughput:** 1 beat/cycle within a packet while m_axis_tready=1. Each packet boundary costs exactly one IDLE cycle with no input accepted.
- **Simultaneous tlast-accept and output-accept:** the output register loads the last beat and m_axis_tvalid stays 1.
- busy is high exactly in BUSY-state cycles.
- No combinational path exists from s_axis_* to m_axis_*.
- s_axis_tready depends combinationally on m_axis_tready and registered state only.

## Test plan
- **Single input, 4-beat packet** (S_COUNT=4, ien=4'b1111, only input 2 valid, tdata 0xA0..0xA3, m_axis_tready=1):
  - output is 0xA0..0xA3 with tlast on the 4th beat and m_axis_tid=2;
  - the first beat appears 2 cycles after tvalid.
- **Round-robin fairness** (all four inputs continuously offering 2-beat packets): grant order is 0,1,2,3,0,1; each packet is contiguous with one gap cycle between packets.
- **Fixed priority** (ARB_MODE=1, inputs 1 and 3 continuously valid): only input 1 is granted. Deassert ien[1]: input 3 is granted at the next packet boundary.
- **Backpressure** (m_axis_tready toggled 1,0,0,1,… during a 6-beat packet from input 0):
  - no beat is lost or duplicated;
  - m_axis_tdata is stable while stalled;
  - s_axis_tready[0]=0 whenever the output is full and stalled.
- **Mid-packet ien drop and tvalid gap** (input 1 packet of 5 beats, clear ien[1] after beat 2, tvalid low 3 cycles after beat 3): all 5 beats are delivered and no other input is granted until tlast.
- **Async reset mid-packet** (assert rst between clock edges during beat 3 of 5):
  - all outputs go to 0 immediately;
  - after release, input 0 wins a 3-way request first.
